// File: rtl/alu_serial_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_serial_seq_if : request/response bundle for the serial ALU       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_serial_seq : bit-serial ALU driving one alu_1bit slice, LSB first|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_1bit (
  input  wire logic       i_a,
  input  wire logic       i_b,
  input  wire logic       i_binvert,
  input  wire logic       i_carry_in,
  input  wire logic       i_less,
  input  wire logic [2:0] i_operation,
  output logic            o_result,
  output logic            o_carry_out
);
  logic w_b;
  logic w_sum;

  always_comb begin
    w_b         = i_b ^ i_binvert;
    w_sum       = i_a ^ w_b ^ i_carry_in;
    o_carry_out = (i_a & w_b) | (i_a & i_carry_in) | (w_b & i_carry_in);
    case (i_operation)
      3'b000:  o_result = i_a & w_b;
      3'b001:  o_result = i_a | w_b;
      3'b011:  o_result = ~(i_a & w_b);
      3'b100:  o_result = ~(i_a | w_b);
      3'b111:  o_result = i_less;
      default: o_result = w_sum;
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input wire logic        clk,
  input wire logic        rst_n,
  alu_serial_seq_if.slave bus
);
  localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIX   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [c_CW-1:0]  r_count;
  logic             r_carry;
  logic [WIDTH-1:0] r_shift;
  logic             r_c_msb_in;
  logic             r_c_out;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_is_slt;
  logic             w_is_arith;
  logic             w_binvert;
  logic [2:0]       w_slice_op;
  logic             w_slice_res;
  logic             w_slice_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_final;
  logic             w_less;

  assign w_is_slt   = (r_op == 3'b111);
  assign w_is_arith = (r_op == 3'b010) || (r_op == 3'b101) || (r_op[2:1] == 2'b11);
  assign w_binvert  = (r_op[2:1] == 2'b11);
  assign w_slice_op = w_is_slt ? 3'b110 : r_op;
  assign w_last     = (r_count == c_CW'(WIDTH - 1));
  assign w_final    = {w_slice_res, r_shift[WIDTH-1:1]};
  // SLT sign: MSB of the difference corrected by signed overflow
  assign w_less     = r_shift[WIDTH-1] ^ (r_c_msb_in ^ r_c_out);

  alu_1bit u_slice (
    .i_a         (r_a[r_count]),
    .i_b         (r_b[r_count]),
    .i_binvert   (w_binvert),
    .i_carry_in  (r_carry),
    .i_less      (1'b0),
    .i_operation (w_slice_op),
    .o_result    (w_slice_res),
    .o_carry_out (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = w_is_slt ? S_FIX : S_DONE;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_shift     <= '0;
      r_c_msb_in  <= 1'b0;
      r_c_out     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_carry <= (bus.op[2:1] == 2'b11);
            r_count <= '0;
          end
        end
        S_SHIFT: begin
          r_shift <= w_final;
          r_carry <= w_slice_cout;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_c_msb_in <= r_carry;
            r_c_out    <= w_slice_cout;
            if (!w_is_slt) begin
              r_result    <= w_final;
              r_zero      <= ~|w_final;
              r_carry_out <= w_is_arith & w_slice_cout;
              r_overflow  <= w_is_arith & (r_carry ^ w_slice_cout);
            end
          end
        end
        S_FIX: begin
          r_result    <= {{(WIDTH-1){1'b0}}, w_less};
          r_zero      <= ~w_less;
          r_carry_out <= r_c_out;
          r_overflow  <= r_c_msb_in ^ r_c_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial ALU sequencer. It drives a single alu_1bit slice, one bit per clock, LSB first, through a WIDTH-bit operation. It sets the slice's Operation, Binvert and CarryIn, and registers the slice carry between cycles. It collects Result bits in a shift register, then applies the SLT fix-up and flag generation. This is the low-area alternative to the ripple-carry array, for the multicycle datapath.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 2..64).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  operation code (encoding below)
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
busy  output  1  high from the cycle after start is accepted until done deasserts
done  output  1  single-cycle completion pulse
result  output  WIDTH  final result, held stable from done until the next accepted start
zero  output  1  result == 0, valid with done and held
carry_out  output  1  carry out of the MSB for ADD/SUB/SLT; 0 for logic ops
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB) for ADD/SUB/SLT; 0 for logic ops

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 110 SUB, 111 SLT.
  - 101 is treated as ADD.
  - SUB and SLT: Binvert=1, and CarryIn=1 on bit 0.
  - All other ops: Binvert=0, and CarryIn=0 on bit 0.
- Slice drive:
  - The slice Operation equals op, except SLT drives 110 (subtract) during shifting.
  - Less is tied to 0.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, result, zero, carry_out and overflow all go to 0.
  - The bit counter, carry flop and operand registers clear.
  - A reset mid-operation aborts the operation with no done pulse.
- States: IDLE -> SHIFT -> (FIX if SLT) -> DONE -> IDLE.
- IDLE:
  - start=1 at edge T latches a, b and op, loads carry flop = CarryIn, sets count=0, and enters SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one edge per bit, edges T+1..T+WIDTH:
  - The slice sees a_reg[count], b_reg[count] and the carry flop.
  - Each edge shifts the result register right, inserting the slice Result at the MSB.
  - Each edge sets carry flop = CarryOut and increments count.
  - On the edge where count=WIDTH-1, record c_msb_in (the carry flop before update) and c_out (the slice CarryOut).
  - Then go to FIX if SLT, else DONE.
- FIX (SLT only, one edge):
  - result = {WIDTH-1 zeros, less}, where less = sum_msb XOR overflow.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy falls together with done.
  - Returns to IDLE on the next edge.
- Latency: done is high in cycle T+WIDTH+1 for non-SLT ops, and in cycle T+WIDTH+2 for SLT.
- Flags:
  - zero, carry_out and overflow are registered along with the final result.
  - They hold their values until the next accepted start.
- start while busy, or in DONE: ignored, with no queuing. The operand inputs may change freely after acceptance.
- Back-to-back: start may be asserted in the cycle after done is high. It is accepted if it is high at the IDLE edge.

Test Plan:
1. WIDTH=8, ADD a=0x7F, b=0x01, start at T -> done in cycle T+9 only; result=0x80, overflow=1, carry_out=0, zero=0.
2. WIDTH=8, SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry_out=1, overflow=0, done at T+9.
3. WIDTH=8, SLT a=0x80, b=0x01 -> result=0x01 (sub=0x7F, overflow=1), done at T+10. Then SLT a=0x02, b=0xFD -> result=0x00.
4. WIDTH=8, logic ops on a=0xF0, b=0x3C:
   - AND -> 0x30, OR -> 0xFC, NAND -> 0xCF.
   - NOR a=0xF0, b=0x0F -> 0x00 with zero=1.
   - carry_out=0 and overflow=0 in all four cases.
   - op=101 on 0x01+0x01 -> 0x02.
5. start pulsed at T+3 during ADD 0x10+0x20 with different operands -> ignored; result=0x30 at T+9, and busy is continuous T+1..T+9.
6. rst_n low at T+4 mid-SUB -> all outputs 0 immediately, no done. After release, ADD 0x01+0xFF -> result=0x00, carry_out=1, zero=1, overflow=0.
